// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
package spi_pkg;

  localparam logic        SPI_CPOL      = 1'b1;
  localparam int unsigned BUS_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    SELECTED = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with registered edge pulses
// that line up with the registered level output.
module spi_sync_edge #(
  parameter int unsigned sync_stages = 2,
  parameter logic        rst_val     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [sync_stages-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // Edges are taken between the last synchronizer stage and the level register,
  // so the metastable first stage never feeds logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {sync_stages{rst_val}};
      level_q <= rst_val;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[sync_stages-2:0], d_i};
      level_q <= sync_q[sync_stages-1];
      rise_q  <= sync_q[sync_stages-1] & ~level_q;
      fall_q  <= ~sync_q[sync_stages-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, CPOL=1: MISO launched on falling SCLK, MOSI sampled on rising
// SCLK, MSB first. All SPI pins are oversampled by clk.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned          bus_width   = BUS_WIDTH_DEF,
  parameter int unsigned          sync_stages = 2,
  parameter logic [bus_width-1:0] idle_fill   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_SPI_Clk,
  input  logic                 i_SPI_MOSI,
  input  logic                 i_SPI_CS_n,
  output logic                 o_SPI_MISO,
  output logic                 o_SPI_MISO_en,
  input  logic [bus_width-1:0] i_TX_Byte,
  input  logic                 i_TX_DV,
  output logic                 o_TX_Ready,
  output logic [bus_width-1:0] o_RX_Byte,
  output logic                 o_RX_DV,
  output logic                 o_TX_Underrun,
  output logic                 o_Frame_Err
);

  localparam int unsigned CNT_W = $clog2(bus_width);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_n_lvl, cs_rise_unused, cs_fall_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.sync_stages(sync_stages), .rst_val(SPI_CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(i_SPI_Clk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.sync_stages(sync_stages), .rst_val(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(i_SPI_CS_n),
    .level_o(cs_n_lvl), .rise_o(cs_rise_unused), .fall_o(cs_fall_unused)
  );

  spi_sync_edge #(.sync_stages(sync_stages), .rst_val(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(i_SPI_MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_t               state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [bus_width-1:0] hold_q;
  logic                 tx_ready_q;
  // Shift registers omit the bit already on MISO / not yet received.
  logic [bus_width-2:0] tx_shift_q;
  logic [bus_width-2:0] rx_shift_q;
  logic [bus_width-1:0] rx_byte_q;
  logic                 miso_q, miso_en_q, rx_dv_q, underrun_q, frame_err_q;

  logic                 selected_c, exit_c, lead_c, trail_c, last_bit_c;
  logic [bus_width-1:0] rx_next_c;
  logic [CNT_W-1:0]     cnt_next_c;

  assign selected_c = (state_q == SELECTED);
  assign exit_c     = selected_c && cs_n_lvl;
  assign lead_c     = selected_c && !cs_n_lvl && sclk_fall;
  assign trail_c    = selected_c && sclk_rise;
  assign last_bit_c = (bit_cnt_q == CNT_W'(bus_width - 1));
  assign rx_next_c  = {rx_shift_q, mosi_lvl};
  assign cnt_next_c = !trail_c   ? bit_cnt_q :
                      last_bit_c ? '0 : bit_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
      rx_dv_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_dv_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // Load and consume are exclusive: one needs the register empty, the other full.
      if (i_TX_DV && tx_ready_q) begin
        hold_q     <= i_TX_Byte;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (!cs_n_lvl) begin
            state_q   <= SELECTED;
            miso_en_q <= 1'b1;
          end
        end
        SELECTED: begin
          if (lead_c) begin
            if (bit_cnt_q != '0) begin
              tx_shift_q <= tx_shift_q << 1;
              miso_q     <= tx_shift_q[bus_width-2];
            end else if (!tx_ready_q) begin
              tx_shift_q <= hold_q[bus_width-2:0];
              miso_q     <= hold_q[bus_width-1];
              tx_ready_q <= 1'b1;
            end else begin
              tx_shift_q <= idle_fill[bus_width-2:0];
              miso_q     <= idle_fill[bus_width-1];
              underrun_q <= 1'b1;
            end
          end

          if (trail_c) begin
            rx_shift_q <= rx_next_c[bus_width-2:0];
            if (last_bit_c) begin
              rx_byte_q <= rx_next_c;
              rx_dv_q   <= 1'b1;
            end
          end
          bit_cnt_q <= cnt_next_c;

          // A deselect that lands on the final trailing edge still completes the word.
          if (exit_c) begin
            state_q   <= IDLE;
            miso_en_q <= 1'b0;
            if (cnt_next_c != '0) begin
              frame_err_q <= 1'b1;
              rx_shift_q  <= '0;
              tx_shift_q  <= '0;
              bit_cnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_en = miso_en_q;
  assign o_TX_Ready    = tx_ready_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_TX_Underrun = underrun_q;
  assign o_Frame_Err   = frame_err_q;

endmodule
